// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer and the instruction decoder:
// FSM state encoding and the decoded instruction IDs.
package core_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  // Instruction IDs produced by the decoder; 0 is deliberately unused so an
  // all-zero decode is treated as illegal.
  localparam int unsigned ID_ADD  = 1;
  localparam int unsigned ID_ADDI = 2;
  localparam int unsigned ID_LUI  = 3;
  localparam int unsigned ID_BNE  = 4;
  localparam int unsigned ID_JAL  = 5;
  localparam int unsigned ID_LW   = 6;
  localparam int unsigned ID_SW   = 7;

endpackage

// File: rtl/seq_wait_cnt.sv
// MEM-state wait counter. Counts cycles while enabled; expired_o flags the
// TIMEOUT-th enabled cycle so the FSM can trap at the end of it.
module seq_wait_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // Count enabled cycles; clear has priority so each MEM visit starts at 0.
  always_ff @(posedge clk) begin
    if (!rst_n)       cnt_q <= '0;
    else if (clear_i) cnt_q <= '0;
    else if (en_i)    cnt_q <= cnt_q + CW'(1);
  end

  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle core control sequencer: FETCH/DECODE/EXEC/MEM/WB walk with a
// retire pulse that steps the PC, a MEM timeout trap and a retire counter.
// All outputs are registered and decoded from the next state.
module core_sequencer
  import core_pkg::*;
#(
  parameter int INST_ID_W   = 8,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 imem_ready,
  input  logic [INST_ID_W-1:0] instID,
  input  logic                 dec_error,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 if_en,
  output logic                 id_en,
  output logic                 ex_en,
  output logic                 wb_en,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 pc_load,
  output logic                 pc_sel,
  output logic [2:0]           state,
  output logic                 trap,
  output logic [CNT_W-1:0]     retired
);

  state_e           state_q, state_d;
  logic             sw_q, sw_d;     // instruction in flight is a store
  logic             jal_q, jal_d;   // instruction in flight is a jump
  logic             retire_d, pc_sel_d;
  logic             mem_expired;
  logic             if_en_q, id_en_q, ex_en_q, wb_en_q;
  logic             mem_req_q, mem_we_q, pc_load_q, pc_sel_q, trap_q;
  logic [CNT_W-1:0] retired_q;

  seq_wait_cnt #(.TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_q != S_MEM),
    .en_i     (state_q == S_MEM),
    .expired_o(mem_expired)
  );

  // Next-state and retire decode; a retire always lands on FETCH or IDLE.
  always_comb begin
    state_d  = state_q;
    sw_d     = sw_q;
    jal_d    = jal_q;
    retire_d = 1'b0;
    pc_sel_d = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        sw_d  = (instID == INST_ID_W'(ID_SW));
        jal_d = (instID == INST_ID_W'(ID_JAL));
        if (dec_error) begin
          state_d = S_TRAP;
        end else if (instID == INST_ID_W'(ID_LW) || instID == INST_ID_W'(ID_SW)) begin
          state_d = S_MEM;
        end else if (instID == INST_ID_W'(ID_ADD) || instID == INST_ID_W'(ID_ADDI) ||
                     instID == INST_ID_W'(ID_LUI) || instID == INST_ID_W'(ID_JAL)) begin
          state_d = S_WB;
        end else if (instID == INST_ID_W'(ID_BNE)) begin
          retire_d = 1'b1;
          pc_sel_d = branch_taken;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        // mem_ready in the timeout cycle still completes the access
        if (mem_ready) begin
          if (sw_q) retire_d = 1'b1;
          else      state_d  = S_WB;
        end else if (mem_expired) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        retire_d = 1'b1;
        pc_sel_d = jal_q;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
    if (retire_d) state_d = start ? S_FETCH : S_IDLE;
  end

  // State, retire counter and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sw_q      <= 1'b0;
      jal_q     <= 1'b0;
      if_en_q   <= 1'b0;
      id_en_q   <= 1'b0;
      ex_en_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      pc_load_q <= 1'b0;
      pc_sel_q  <= 1'b0;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      sw_q      <= sw_d;
      jal_q     <= jal_d;
      if_en_q   <= (state_d == S_FETCH);
      id_en_q   <= (state_d == S_DECODE);
      ex_en_q   <= (state_d == S_EXEC);
      wb_en_q   <= (state_d == S_WB);
      mem_req_q <= (state_d == S_MEM);
      mem_we_q  <= (state_d == S_MEM) && sw_d;
      pc_load_q <= retire_d;
      pc_sel_q  <= pc_sel_d;
      trap_q    <= (state_d == S_TRAP);
      if (retire_d) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign if_en   = if_en_q;
  assign id_en   = id_en_q;
  assign ex_en   = ex_en_q;
  assign wb_en   = wb_en_q;
  assign mem_req = mem_req_q;
  assign mem_we  = mem_we_q;
  assign pc_load = pc_load_q;
  assign pc_sel  = pc_sel_q;
  assign trap    = trap_q;
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Table-driven bench for core_sequencer with a per-cycle scoreboard, plus a
// hand-written retire-counter wrap sequence on a narrow-counter instance.
module tb_core_sequencer;
  import core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0, start = 1'b0, imem_ready = 1'b0;
  logic [7:0] instID = '0;
  logic       dec_error = 1'b0, branch_taken = 1'b0, mem_ready = 1'b0;

  logic        if_en, id_en, ex_en, wb_en, mem_req, mem_we, pc_load, pc_sel, trap;
  logic [2:0]  state;
  logic [31:0] retired;

  logic        w_if, w_id, w_ex, w_wb, w_mreq, w_mwe, w_pcl, w_pcs, w_trap;
  logic [2:0]  w_state;
  logic [1:0]  w_retired;

  core_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_ready(imem_ready),
    .instID(instID), .dec_error(dec_error), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .if_en(if_en), .id_en(id_en), .ex_en(ex_en),
    .wb_en(wb_en), .mem_req(mem_req), .mem_we(mem_we), .pc_load(pc_load),
    .pc_sel(pc_sel), .state(state), .trap(trap), .retired(retired)
  );

  // Narrow retire counter so the wrap-around can be reached in a few retires.
  core_sequencer #(.CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_ready(imem_ready),
    .instID(instID), .dec_error(dec_error), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .if_en(w_if), .id_en(w_id), .ex_en(w_ex),
    .wb_en(w_wb), .mem_req(w_mreq), .mem_we(w_mwe), .pc_load(w_pcl),
    .pc_sel(w_pcs), .state(w_state), .trap(w_trap), .retired(w_retired)
  );

  typedef struct {
    logic        rst, st, im;
    logic [7:0]  id;
    logic        de, bt, mr;
    state_e      es;
    logic        pl, ps, we;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic rst, logic st, logic im, int id, logic de,
                              logic bt, logic mr, state_e es, logic pl,
                              logic ps, logic we, int ret);
    vec_t v;
    v.rst = rst; v.st = st; v.im = im; v.id = 8'(id); v.de = de; v.bt = bt;
    v.mr = mr; v.es = es; v.pl = pl; v.ps = ps; v.we = we; v.ret = 32'(ret);
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic cyc(input vec_t v, input string nm);
    vec_t e;
    logic [11:0] act, exp;
    @(negedge clk);
    rst_n = v.rst; start = v.st; imem_ready = v.im; instID = v.id;
    dec_error = v.de; branch_taken = v.bt; mem_ready = v.mr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    exp = {e.es, e.es == S_FETCH, e.es == S_DECODE, e.es == S_EXEC,
           e.es == S_MEM, e.we, e.es == S_WB, e.pl, e.ps, e.es == S_TRAP};
    act = {state, if_en, id_en, ex_en, mem_req, mem_we, wb_en, pc_load, pc_sel, trap};
    chk({nm, "_outs"}, 64'(act), 64'(exp));
    chk({nm, "_retired"}, 64'(retired), 64'(e.ret));
  endtask

  // FETCH (start held), DECODE, EXEC prefix of one instruction.
  task automatic pre(int ret);
    tbl.push_back(mk(1,1,0,0,0,0,0, S_FETCH,  0,0,0, ret));
    tbl.push_back(mk(1,1,1,0,0,0,0, S_DECODE, 0,0,0, ret));
    tbl.push_back(mk(1,1,0,0,0,0,0, S_EXEC,   0,0,0, ret));
  endtask

  task automatic rst_row();
    tbl.push_back(mk(0,0,0,0,0,0,0, S_IDLE, 0,0,0, 0));
  endtask

  initial begin
    // reset, idle without start
    rst_row();
    tbl.push_back(mk(1,0,0,0,0,0,0, S_IDLE, 0,0,0, 0));
    // ADDI, start dropped at retire -> IDLE
    pre(0);
    tbl.push_back(mk(1,1,0,ID_ADDI,0,0,0, S_WB,   0,0,0, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0,       S_IDLE, 1,0,0, 1));
    // BNE taken with a fetch stall
    tbl.push_back(mk(1,1,0,0,0,0,0, S_FETCH, 0,0,0, 1));
    pre(1);
    tbl.push_back(mk(1,1,0,ID_BNE,0,1,0, S_FETCH, 1,1,0, 2));
    // BNE not taken
    tbl.push_back(mk(1,1,1,0,0,0,0, S_DECODE, 0,0,0, 2));
    tbl.push_back(mk(1,1,0,0,0,0,0, S_EXEC,   0,0,0, 2));
    tbl.push_back(mk(1,1,0,ID_BNE,0,0,0, S_FETCH, 1,0,0, 3));
    // JAL
    tbl.push_back(mk(1,1,1,0,0,0,0, S_DECODE, 0,0,0, 3));
    tbl.push_back(mk(1,1,0,0,0,0,0, S_EXEC,   0,0,0, 3));
    tbl.push_back(mk(1,1,0,ID_JAL,0,0,0, S_WB,    0,0,0, 3));
    tbl.push_back(mk(1,1,0,0,0,0,0,      S_FETCH, 1,1,0, 4));
    // LW, mem_ready on the 4th MEM cycle
    tbl.push_back(mk(1,1,1,0,0,0,0, S_DECODE, 0,0,0, 4));
    tbl.push_back(mk(1,1,0,0,0,0,0, S_EXEC,   0,0,0, 4));
    tbl.push_back(mk(1,1,0,ID_LW,0,0,0, S_MEM, 0,0,0, 4));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,1,0,0,0,0,0, S_MEM, 0,0,0, 4));
    tbl.push_back(mk(1,1,0,0,0,0,1, S_WB,    0,0,0, 4));
    tbl.push_back(mk(1,1,0,0,0,0,0, S_FETCH, 1,0,0, 5));
    // SW with start dropped mid-access: completes, retires, no WB, then IDLE
    tbl.push_back(mk(1,1,1,0,0,0,0, S_DECODE, 0,0,0, 5));
    tbl.push_back(mk(1,1,0,0,0,0,0, S_EXEC,   0,0,0, 5));
    tbl.push_back(mk(1,1,0,ID_SW,0,0,0, S_MEM,  0,0,1, 5));
    tbl.push_back(mk(1,0,0,0,0,0,0,     S_MEM,  0,0,1, 5));
    tbl.push_back(mk(1,0,0,0,0,0,1,     S_IDLE, 1,0,0, 6));
    // unknown instruction ID -> TRAP, held
    pre(6);
    tbl.push_back(mk(1,1,0,0,0,0,0, S_TRAP, 0,0,0, 6));
    tbl.push_back(mk(1,1,1,0,0,0,1, S_TRAP, 0,0,0, 6));
    tbl.push_back(mk(1,1,1,0,0,0,0, S_TRAP, 0,0,0, 6));
    rst_row();
    // ADD retires, then dec_error beats a legal ID -> TRAP, retired unchanged
    pre(0);
    tbl.push_back(mk(1,1,0,ID_ADD,0,0,0, S_WB,    0,0,0, 0));
    tbl.push_back(mk(1,1,0,0,0,0,0,      S_FETCH, 1,0,0, 1));
    tbl.push_back(mk(1,1,1,0,0,0,0, S_DECODE, 0,0,0, 1));
    tbl.push_back(mk(1,1,0,0,0,0,0, S_EXEC,   0,0,0, 1));
    tbl.push_back(mk(1,1,0,ID_ADD,1,0,0, S_TRAP, 0,0,0, 1));
    tbl.push_back(mk(1,1,1,0,0,0,0,      S_TRAP, 0,0,0, 1));
    rst_row();
    // LW timeout: 15 MEM cycles then TRAP, held; reset clears trap
    pre(0);
    tbl.push_back(mk(1,1,0,ID_LW,0,0,0, S_MEM, 0,0,0, 0));
    for (int k = 0; k < 14; k++) tbl.push_back(mk(1,1,0,0,0,0,0, S_MEM, 0,0,0, 0));
    tbl.push_back(mk(1,1,0,0,0,0,0, S_TRAP, 0,0,0, 0));
    tbl.push_back(mk(1,1,0,0,0,0,1, S_TRAP, 0,0,0, 0));
    tbl.push_back(mk(1,1,1,0,0,0,0, S_TRAP, 0,0,0, 0));
    rst_row();
    // mem_ready in the timeout cycle wins
    pre(0);
    tbl.push_back(mk(1,1,0,ID_LW,0,0,0, S_MEM, 0,0,0, 0));
    for (int k = 0; k < 14; k++) tbl.push_back(mk(1,1,0,0,0,0,0, S_MEM, 0,0,0, 0));
    tbl.push_back(mk(1,1,0,0,0,0,1, S_WB,   0,0,0, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0, S_IDLE, 1,0,0, 1));
    // reset mid-MEM: request dropped, not reissued, core idles
    pre(1);
    tbl.push_back(mk(1,1,0,ID_SW,0,0,0, S_MEM, 0,0,1, 1));
    tbl.push_back(mk(0,0,0,0,0,0,0, S_IDLE, 0,0,0, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0, S_IDLE, 0,0,0, 0));
    tbl.push_back(mk(1,0,0,0,0,0,1, S_IDLE, 0,0,0, 0));

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], $sformatf("row%0d", i));

    // Wrap: five back-to-back ADDIs; the 2-bit counter rolls over to 0.
    cyc(mk(0,0,0,0,0,0,0, S_IDLE,  0,0,0, 0), "wrap_rst");
    cyc(mk(1,1,0,0,0,0,0, S_FETCH, 0,0,0, 0), "wrap_fetch");
    for (int n = 1; n <= 5; n++) begin
      cyc(mk(1,1,1,0,0,0,0,       S_DECODE, 0,0,0, n-1), $sformatf("wrap%0d_dec", n));
      cyc(mk(1,1,0,0,0,0,0,       S_EXEC,   0,0,0, n-1), $sformatf("wrap%0d_ex", n));
      cyc(mk(1,1,0,ID_ADDI,0,0,0, S_WB,     0,0,0, n-1), $sformatf("wrap%0d_wb", n));
      cyc(mk(1,1,0,0,0,0,0,       S_FETCH,  1,0,0, n),   $sformatf("wrap%0d_ret", n));
      chk($sformatf("wrap%0d_narrow_retired", n), 64'(w_retired), 64'(n % 4));
      chk($sformatf("wrap%0d_narrow_pc_load", n), 64'(w_pcl), 64'(1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter INST_ID_W, default 8, width of instID (equal to InstIDDepth).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, maximum MEM-state wait cycles before trap.
REQ-003 SHALL have parameter CNT_W, default 32, width of the retire counter.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  in  1  run enable; sampled in IDLE and at instruction boundaries.
REQ-007 SHALL have port imem_ready  in  1  instruction word valid this cycle.
REQ-008 SHALL have port instID  in  INST_ID_W  decoded instruction ID, valid in EXEC.
REQ-009 SHALL have port dec_error  in  1  decoder error flag, valid in EXEC.
REQ-010 SHALL have port branch_taken  in  1  BNE compare result, valid in EXEC.
REQ-011 SHALL have port mem_ready  in  1  data-memory access complete.
REQ-012 SHALL have ports if_en, id_en, ex_en, wb_en  out  1 each  stage enables.
REQ-013 SHALL have ports mem_req, mem_we  out  1 each  data-memory request / write qualifier.
REQ-014 SHALL have port pc_load  out  1  one-cycle pulse: PC takes next value.
REQ-015 SHALL have port pc_sel  out  1  with pc_load: 1 = branch/jump target, 0 = PC+4.
REQ-016 SHALL have ports state  out  3, trap  out  1, retired  out  CNT_W  (status/debug).

Function
REQ-017 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP; outputs registered, decoded from the next state.
REQ-018 IDLE: start=1 -> FETCH; else stay.
REQ-019 FETCH: if_en=1; imem_ready=1 -> DECODE; else stay (no timeout).
REQ-020 DECODE: id_en=1 for exactly one cycle -> EXEC (decoder latency is one cycle).
REQ-021 EXEC: dec_error=1 -> TRAP, takes priority over every other decode; else ex_en=1 for one cycle.
REQ-022 EXEC with ID_LW or ID_SW -> MEM; ID_ADD, ID_ADDI, ID_LUI, ID_JAL -> WB; ID_BNE -> retire, no WB; any other ID -> TRAP.
REQ-023 MEM: mem_req=1 held until mem_ready; mem_we=1 only for ID_SW; on mem_ready, LW -> WB, SW -> retire.
REQ-024 MEM: wait counter starts at 0 on entry; if it reaches MEM_TIMEOUT without mem_ready -> TRAP; mem_ready in the same cycle as the timeout wins.
REQ-025 WB: wb_en=1 for exactly one cycle -> retire.
REQ-026 Retire: pc_load=1 for one cycle, retired+1 (wraps modulo 2^CNT_W); pc_sel=1 for JAL, or for BNE with branch_taken=1; else 0.
REQ-027 After retire: start=1 -> FETCH, start=0 -> IDLE; start deasserted mid-instruction SHALL NOT abort it.
REQ-028 TRAP: trap=1, every enable/request 0, no pc_load; stays until rst_n=0.
REQ-029 Stage enables SHALL be mutually exclusive; at most one of if_en/id_en/ex_en/mem_req/wb_en high per cycle.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE, all outputs 0, retired=0, wait counter=0, from any state including MEM and TRAP.
REQ-031 A mem_req dropped by reset mid-access SHALL NOT be reissued; after reset the core restarts from IDLE.

Structure
REQ-032 State encoding, and instID constants shared with the decoder (ID_ADD, ID_ADDI, ID_LUI, ID_BNE, ID_JAL, ID_LW, ID_SW), SHALL be in package core_pkg.
REQ-033 The MEM wait counter SHALL be a sub-module seq_wait_cnt (clear, enable, expired output); everything else stays in core_sequencer.

Verification
REQ-034 ADDI: start=1, imem_ready=1 -> FETCH, DECODE, EXEC, WB, then pc_load=1 with pc_sel=0; retired=1 after 5 cycles.
REQ-035 BNE, branch_taken=1 -> no wb_en; pc_load=1 with pc_sel=1 in the cycle after EXEC; retired increments.
REQ-036 LW with mem_ready after 3 cycles -> mem_req high 4 cycles, mem_we=0, then WB, then retire; SW -> mem_we=1, no WB.
REQ-037 LW, mem_ready never asserted -> TRAP after 15 MEM cycles, trap=1 and held; rst_n=0 -> IDLE, trap=0, retired=0.
REQ-038 dec_error=1 in EXEC -> TRAP next cycle, no pc_load, retired unchanged.
REQ-039 start dropped during MEM -> instruction completes and retires, then IDLE; retired=0xFFFFFFFF plus one retire -> 0.
